// File: rtl/pll_rst_sequencer.sv
// ---------------------------------------------------------------------------
// pll_rst_sequencer
//   Sequences resets for up to N_PLL PLLs from software request bits driven
//   by the NIOS PLL_RST PIO. Only one PLL is sequenced at a time, and pending
//   requests are served round-robin.
//   For each PLL the block holds areset for RST_CYCLES, waits up to
//   LOCK_TIMEOUT cycles for lock, and then requires LOCK_STABLE consecutive
//   locked cycles. It reports the result as sticky done/err bits.
//
// Build option:
//   PLL_RST_SYNC_EN  defined   -> pll_locked goes through a 2-flop
//                                 synchroniser per bit (adds 2 cycles).
//                    undefined -> pll_locked is used directly (clk domain).
//
// Ports:
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   pll_rst_req  in   N_PLL  rising edge on bit i requests a sequence for PLL i
//   pll_locked   in   N_PLL  PLL lock indicators
//   pll_areset   out  N_PLL  PLL reset outputs, active high
//   pll_done     out  N_PLL  sticky: last sequence completed with stable lock
//   pll_err      out  N_PLL  sticky: last sequence timed out waiting for lock
//   busy         out  1      a sequence is in progress
//   active_idx   out  3      PLL currently being sequenced (valid while busy)
// ---------------------------------------------------------------------------

`ifdef PLL_RST_SYNC_EN
// Per-bit two-flop synchroniser for the lock indicators.
module pll_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule
`endif

module pll_rst_sequencer #(
    parameter int N_PLL        = 4,
    parameter int CNT_W        = 16,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_PLL-1:0] pll_rst_req,
    input  logic [N_PLL-1:0] pll_locked,
    output logic [N_PLL-1:0] pll_areset,
    output logic [N_PLL-1:0] pll_done,
    output logic [N_PLL-1:0] pll_err,
    output logic             busy,
    output logic [2:0]       active_idx
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_LOCK, S_SETTLE} state_t;

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LOAD = CNT_W'(LOCK_STABLE - 1);
    localparam logic [2:0]       LAST_INIT = 3'(N_PLL - 1);

    state_t           state;
    logic [N_PLL-1:0] pending;
    logic [N_PLL-1:0] req_d;
    logic [2:0]       last_grant;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stab;

    logic [N_PLL-1:0] locked_s;
    logic [N_PLL-1:0] req_rise;
    logic [N_PLL-1:0] act_mask;
    logic [N_PLL-1:0] gnt_mask;
    logic [N_PLL-1:0] cand;
    logic [2:0]       gnt_idx;
    logic             gnt_found;
    logic             act_locked;

`ifdef PLL_RST_SYNC_EN
    for (genvar i = 0; i < N_PLL; i++) begin : g_sync
        pll_lock_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (pll_locked[i]),
            .q     (locked_s[i])
        );
    end
`else
    assign locked_s = pll_locked;
`endif

    assign req_rise   = pll_rst_req & ~req_d;
    assign act_mask   = N_PLL'(1) << active_idx;
    assign act_locked = |(locked_s & act_mask);

    // Round-robin search starting just after last_grant. The loop runs from
    // the farthest candidate to the nearest, so the nearest pending one is
    // assigned last and wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = N_PLL; k >= 1; k--) begin
            cand = N_PLL'(1) << ((int'(last_grant) + k) % N_PLL);
            if (|(pending & cand)) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'((int'(last_grant) + k) % N_PLL);
            end
        end
    end

    assign gnt_mask = N_PLL'(1) << gnt_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pll_areset <= '1;
            pending    <= '1;        // every PLL is sequenced after reset
            req_d      <= '0;
            pll_done   <= '0;
            pll_err    <= '0;
            busy       <= 1'b0;
            active_idx <= '0;
            last_grant <= LAST_INIT;
            cnt        <= '0;
            stab       <= '0;
        end else begin
            req_d   <= pll_rst_req;
            // A new edge always lands in pending, even for the active PLL,
            // so that PLL is re-run after the current sequence.
            pending <= pending | req_rise;

            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        // If an edge arrives in the grant cycle, it keeps the
                        // bit set.
                        pending    <= (pending & ~gnt_mask) | req_rise;
                        active_idx <= gnt_idx;
                        last_grant <= gnt_idx;
                        pll_areset <= pll_areset | gnt_mask;
                        pll_done   <= pll_done & ~gnt_mask;
                        pll_err    <= pll_err & ~gnt_mask;
                        cnt        <= RST_LOAD;
                        busy       <= 1'b1;
                        state      <= S_ASSERT;
                    end
                end

                S_ASSERT: begin
                    if (cnt == '0) begin
                        pll_areset <= pll_areset & ~act_mask;
                        cnt        <= TO_LOAD;
                        state      <= S_WAIT_LOCK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (act_locked) begin
                        stab  <= STAB_LOAD;
                        state <= S_SETTLE;
                    end else if (cnt == '0) begin
                        pll_err <= pll_err | act_mask;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_SETTLE: begin
                    // On lock loss, return without reloading cnt. The
                    // overall lock deadline keeps running across glitches.
                    if (!act_locked) begin
                        state <= S_WAIT_LOCK;
                    end else if (stab == '0) begin
                        pll_done <= pll_done | act_mask;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        stab <= stab - 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_rst_sequencer
//   Directed bench for pll_rst_sequencer with N_PLL=4, RST_CYCLES=16,
//   LOCK_TIMEOUT=100 and LOCK_STABLE=8.
//   A behavioural PLL model asserts lock 20 cycles after areset falls. Each
//   PLL has a mode: 0 normal, 1 never locks, 2 one-cycle dropout,
//   3 permanent dropout after first lock.
//   A negedge monitor timestamps areset/done/err edges and logs grant order.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pll_rst_sequencer;

    localparam int N    = 4;
    localparam int RSTC = 16;
    localparam int TO   = 100;
    localparam int STB  = 8;
    localparam int LKD  = 20;
`ifdef PLL_RST_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] pll_rst_req = '0;
    logic [N-1:0] pll_locked = '0;
    logic [N-1:0] pll_areset;
    logic [N-1:0] pll_done;
    logic [N-1:0] pll_err;
    logic         busy;
    logic [2:0]   active_idx;

    always #5 clk = ~clk;

    pll_rst_sequencer #(
        .N_PLL(N), .CNT_W(16), .RST_CYCLES(RSTC),
        .LOCK_TIMEOUT(TO), .LOCK_STABLE(STB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_rst_req(pll_rst_req),
        .pll_locked (pll_locked),
        .pll_areset (pll_areset),
        .pll_done   (pll_done),
        .pll_err    (pll_err),
        .busy       (busy),
        .active_idx (active_idx)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor and PLL model
    int     cyc = 0;
    int     fall_t[N], rise_t[N], done_t[N], err_t[N], grant_t[N];
    int     lk_cnt[N];
    int     mode[N];
    int     glog[$];
    logic [N-1:0] prev_ar = '1, prev_done = '0, prev_err = '0;
    logic         prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (prev_ar[i] && !pll_areset[i])     fall_t[i] = cyc;
            if (!prev_ar[i] && pll_areset[i])     rise_t[i] = cyc;
            if (!prev_done[i] && pll_done[i])     done_t[i] = cyc;
            if (!prev_err[i] && pll_err[i])       err_t[i]  = cyc;
        end
        if (!prev_busy && busy) begin
            glog.push_back(int'(active_idx));
            grant_t[int'(active_idx) % N] = cyc;
        end
        prev_ar   = pll_areset;
        prev_done = pll_done;
        prev_err  = pll_err;
        prev_busy = busy;
        for (int i = 0; i < N; i++) begin
            if (pll_areset[i] !== 1'b0) lk_cnt[i] = 0;
            else if (lk_cnt[i] < 1000)  lk_cnt[i]++;
            pll_locked[i] = (pll_areset[i] === 1'b0) && (lk_cnt[i] >= LKD) && (mode[i] != 1)
                            && !(mode[i] == 2 && lk_cnt[i] == 25)
                            && !(mode[i] == 3 && lk_cnt[i] >= 25);
        end
    end

    task automatic pulse(input logic [N-1:0] m);
        @(negedge clk);
        pll_rst_req = m;
        @(negedge clk);
        pll_rst_req = '0;
    endtask

    // Wait until the sequencer has been idle for 4 consecutive cycles.
    task automatic wait_quiet(input string tag, input int max_cyc);
        int idle_run;
        int n;
        idle_run = 0;
        n = 0;
        while (idle_run < 4 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (!busy) idle_run++;
            else       idle_run = 0;
        end
        chk({tag, "_quiet"}, idle_run, 4);
    endtask

    // Compare the grant log with n expected indices, packed 4 bits each.
    task automatic chk_log(input string tag, input int n, input logic [31:0] seq);
        chk({tag, "_cnt"}, glog.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_g%0d", tag, i), (i < glog.size()) ? glog[i] : -1, 32'(seq[4*i +: 4]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) mode[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_areset", pll_areset, 4'hF);
        chk("rst_done",   pll_done,   4'h0);
        chk("rst_err",    pll_err,    4'h0);
        chk("rst_busy",   busy,       1'b0);
        chk("rst_idx",    active_idx, 3'd0);

        // T1: all PLLs are sequenced after reset in order 0..3
        glog.delete();
        reset = 1'b0;
        for (int n = 0; n < 100 && pll_areset[0]; n++) @(negedge clk);
        chk("t1_others_held", pll_areset, 4'b1110);
        wait_quiet("t1", 600);
        chk_log("t1_order", 4, 32'h3210);
        for (int i = 0; i < N; i++)
            chk($sformatf("t1_rst_len%0d", i), fall_t[i] - grant_t[i], RSTC);
        chk("t1_done", pll_done, 4'hF);
        chk("t1_err",  pll_err,  4'h0);
        chk("t1_busy", busy,     1'b0);

        // T2: a single request for PLL2
        glog.delete();
        pulse(4'b0100);
        for (int n = 0; n < 10 && !pll_areset[2]; n++) @(negedge clk);
        chk("t2_areset_only2", pll_areset, 4'b0100);
        chk("t2_done_cleared", pll_done,   4'b1011);
        wait_quiet("t2", 300);
        chk("t2_rst_len",  fall_t[2] - rise_t[2], RSTC);
        chk("t2_done_lat", done_t[2] - fall_t[2], LKD + STB + SD);
        chk("t2_done",     pll_done, 4'hF);
        chk_log("t2_order", 1, 32'h2);

        // T2b: a re-request while PLL2 is active reruns it
        glog.delete();
        pulse(4'b0100);
        repeat (5) @(negedge clk);
        pulse(4'b0100);
        wait_quiet("t2b", 300);
        chk_log("t2b_order", 2, 32'h22);

        // T3: PLL1 never locks; a pending PLL3 is served afterwards
        mode[1] = 1;
        glog.delete();
        pulse(4'b0010);
        repeat (5) @(negedge clk);
        pulse(4'b1000);
        wait_quiet("t3", 600);
        chk("t3_err_lat", err_t[1] - fall_t[1], TO);
        chk("t3_err",     pll_err,  4'b0010);
        chk("t3_done",    pll_done, 4'b1101);
        chk_log("t3_order", 2, 32'h31);
        mode[1] = 0;

        // T4: last_grant=1, simultaneous edges on 1 and 3 -> 3 first
        glog.delete();
        pulse(4'b0010);
        wait_quiet("t4a", 300);
        glog.delete();
        pulse(4'b1010);
        wait_quiet("t4", 300);
        chk_log("t4_order", 2, 32'h13);
        chk("t4_done", pll_done, 4'hF);
        chk("t4_err",  pll_err,  4'h0);

        // T5: one-cycle lock drop at SETTLE stab=3
        mode[0] = 2;
        glog.delete();
        pulse(4'b0001);
        wait_quiet("t5", 300);
        chk("t5_done_lat", done_t[0] - fall_t[0], 34 + SD);
        chk("t5_done", pll_done, 4'hF);
        chk("t5_err",  pll_err,  4'h0);
        mode[0] = 0;

        // T7: lock lost permanently in SETTLE; the deadline is not restarted
        mode[2] = 3;
        pulse(4'b0100);
        wait_quiet("t7", 400);
        chk("t7_err_lat", err_t[2] - fall_t[2], 106);
        chk("t7_err",  pll_err,  4'b0100);
        chk("t7_done", pll_done, 4'b1011);
        mode[2] = 0;

        // T6: reset while PLL2 is in WAIT_LOCK
        mode[2] = 1;
        pulse(4'b0100);
        for (int n = 0; n < 10 && !pll_areset[2]; n++) @(negedge clk);
        for (int n = 0; n < 40 && pll_areset[2]; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t6_busy_pre", busy, 1'b1);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_areset", pll_areset, 4'hF);
        chk("t6_done",   pll_done,   4'h0);
        chk("t6_err",    pll_err,    4'h0);
        chk("t6_busy",   busy,       1'b0);
        mode[2] = 0;
        glog.delete();
        @(negedge clk);
        reset = 1'b0;
        wait_quiet("t6", 600);
        chk_log("t6_order", 4, 32'h3210);
        chk("t6_done_end", pll_done, 4'hF);
        chk("t6_err_end",  pll_err,  4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
